// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the CPU-to-memory access controller
//
// Holds the access-size encoding presented on i_mode, the controller FSM state
// encoding, and the mapping from access size to a byte count.
package mem_pkg;

    // Access size as presented on i_mode.
    typedef enum logic [1:0] {
        MODE_NONE = 2'd0,
        MODE_16   = 2'd1,
        MODE_32   = 2'd2,
        MODE_8    = 2'd3
    } mem_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RDWAIT,
        ST_DONE
    } mem_state_e;

    // Number of bytes moved by an access of the given size (0 for MODE_NONE).
    function automatic logic [2:0] size_bytes(input mem_mode_e mode);
        case (mode)
            MODE_8:  size_bytes = 3'd1;
            MODE_16: size_bytes = 3'd2;
            MODE_32: size_bytes = 3'd4;
            default: size_bytes = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane steering and load extension for one memory beat
//
// Purely combinational.
//   mode       access size (mem_mode_e encoding)
//   sign_ext   sign-extend 8/16-bit load results
//   offset     byte offset of the access inside a memory word (0 when MB == 1)
//   beat       index of the beat currently on the memory bus
//   wdata      right-aligned CPU store data
//   rdata_raw  assembled load data, beat 0 in the lowest memory-word slot
//   lane_wdata memory write data for the current beat
//   lane_be    byte lanes touched by the access
//   rdata      right-aligned, extended load result
module mem_lane_align
    import mem_pkg::*;
#(
    parameter int MEM_WIDTH = 16
)
(
    input  logic [1:0]             mode,
    input  logic                   sign_ext,
    input  logic [1:0]             offset,
    input  logic [1:0]             beat,
    input  logic [31:0]            wdata,
    input  logic [31:0]            rdata_raw,
    output logic [MEM_WIDTH-1:0]   lane_wdata,
    output logic [MEM_WIDTH/8-1:0] lane_be,
    output logic [31:0]            rdata
);

    localparam int MB = MEM_WIDTH / 8;

    logic [2:0]  nbytes;
    logic        wide;
    logic [31:0] wsh;
    logic [31:0] rsh;

    always_comb begin
        nbytes     = size_bytes(mem_mode_e'(mode));
        // A "wide" access covers at least one whole memory word per beat, so
        // every lane is used and the data is sliced per beat. Otherwise the
        // access sits inside a single word and only some lanes are enabled.
        wide       = (int'(nbytes) >= MB);
        wsh        = wdata >> (int'(beat) * MEM_WIDTH);
        lane_wdata = '0;
        lane_be    = '0;
        for (int i = 0; i < MB; i++) begin
            if (wide) begin
                lane_wdata[8*i +: 8] = wsh[8*i +: 8];
                lane_be[i]           = 1'b1;
            end else begin
                // Replicate the store data across the word; byte enables pick
                // out the lanes that are actually written.
                lane_wdata[8*i +: 8] = (nbytes == 3'd1) ? wdata[7:0] : wdata[8*(i%2) +: 8];
                lane_be[i]           = (i >= int'(offset)) && (i < int'(offset) + int'(nbytes));
            end
        end

        rsh = wide ? rdata_raw : (rdata_raw >> (int'(offset) * 8));
        case (nbytes)
            3'd1:    rdata = {{24{sign_ext & rsh[7]}}, rsh[7:0]};
            3'd2:    rdata = {{16{sign_ext & rsh[15]}}, rsh[15:0]};
            default: rdata = rsh;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - splits CPU 8/16/32-bit accesses into memory-word beats
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   i_req/o_ready          request handshake, accepted when both are high
//   i_we, i_mode, i_signed store/load, access size, sign-extend loads
//   i_addr, i_wdata        byte address, right-aligned store data
//   o_done, o_err          one-cycle completion pulse, rejection flag with it
//   o_rdata                load result, held until the next load completes
//   o_mem_en/we/addr/wdata memory beat interface (per-lane write enables)
//   i_mem_rdata            memory read data, one cycle after a read beat
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter  int MEM_WIDTH = 16,
    parameter  int MEM_DEPTH = 4096,
    localparam int MB        = MEM_WIDTH / 8,
    localparam int AW        = $clog2(MEM_DEPTH * MB),
    localparam int WW        = $clog2(MEM_DEPTH)
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [1:0]           i_mode,
    input  logic                 i_signed,
    input  logic [AW-1:0]        i_addr,
    input  logic [31:0]          i_wdata,
    output logic                 o_ready,
    output logic                 o_done,
    output logic                 o_err,
    output logic [31:0]          o_rdata,
    output logic                 o_mem_en,
    output logic [MB-1:0]        o_mem_we,
    output logic [WW-1:0]        o_mem_addr,
    output logic [MEM_WIDTH-1:0] o_mem_wdata,
    input  logic [MEM_WIDTH-1:0] i_mem_rdata
);

    localparam int OW     = $clog2(MB);
    localparam int NB_MAX = 4 / MB;

    mem_state_e state_q, state_d;

    logic [1:0]  beat_q;
    logic [AW-1:0] addr_q;
    mem_mode_e   mode_q;
    logic        we_q;
    logic        sgn_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic        rd_prev_q;
    logic [1:0]  rd_beat_q;
    logic [31:0] asm_q;
    logic [31:0] asm_next;
    logic [31:0] rdata_q;

    mem_mode_e   mode_in;
    logic [2:0]  bytes_in;
    logic        bad_in;
    logic [2:0]  bytes_q;
    logic [1:0]  beat_last;
    logic        accept;
    logic        mem_en;
    logic [WW-1:0] word_base;
    logic [1:0]  offset;

    logic [MEM_WIDTH-1:0] lane_wdata;
    logic [MB-1:0]        lane_be;
    logic [31:0]          align_rdata;

    assign o_ready = (state_q == ST_IDLE) & ~rst;
    assign accept  = i_req & o_ready;

    // Request decode at acceptance: unsupported size or misaligned address is
    // rejected without touching memory.
    always_comb begin
        mode_in  = mem_mode_e'(i_mode);
        bytes_in = size_bytes(mode_in);
        bad_in   = (mode_in == MODE_NONE)
                || ((bytes_in == 3'd2) && i_addr[0])
                || ((bytes_in == 3'd4) && (i_addr[1:0] != 2'b00));
    end

    always_comb begin
        bytes_q = size_bytes(mode_q);
        if (int'(bytes_q) > MB) begin
            beat_last = 2'(int'(bytes_q) / MB - 1);
        end else begin
            beat_last = 2'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_en  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = bad_in ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_en = 1'b1;
                if (beat_q == beat_last) begin
                    // Loads need one more cycle for the last beat's data.
                    state_d = we_q ? ST_DONE : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Read data for the beat issued last cycle lands in its word slot.
    always_comb begin
        asm_next = asm_q;
        if (rd_prev_q) begin
            for (int b = 0; b < NB_MAX; b++) begin
                if (rd_beat_q == 2'(b)) begin
                    asm_next[b*MEM_WIDTH +: MEM_WIDTH] = i_mem_rdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q    <= 2'd0;
            addr_q    <= '0;
            mode_q    <= MODE_NONE;
            we_q      <= 1'b0;
            sgn_q     <= 1'b0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            rd_prev_q <= 1'b0;
            rd_beat_q <= 2'd0;
            asm_q     <= '0;
            rdata_q   <= '0;
        end else begin
            rd_prev_q <= mem_en & ~we_q;
            rd_beat_q <= beat_q;
            if (accept) begin
                addr_q  <= i_addr;
                mode_q  <= mode_in;
                we_q    <= i_we;
                sgn_q   <= i_signed;
                wdata_q <= i_wdata;
                err_q   <= bad_in;
                beat_q  <= 2'd0;
                asm_q   <= '0;
            end else begin
                asm_q <= asm_next;
                if (state_q == ST_ISSUE) begin
                    beat_q <= beat_q + 2'd1;
                end
            end
            // asm_next already includes the final beat during RDWAIT.
            if (state_q == ST_RDWAIT) begin
                rdata_q <= align_rdata;
            end
        end
    end

    assign word_base = WW'(addr_q >> OW);
    assign offset    = addr_q[1:0] & 2'(MB - 1);

    mem_lane_align #(
        .MEM_WIDTH (MEM_WIDTH)
    ) u_align (
        .mode       (mode_q),
        .sign_ext   (sgn_q),
        .offset     (offset),
        .beat       (beat_q),
        .wdata      (wdata_q),
        .rdata_raw  (asm_next),
        .lane_wdata (lane_wdata),
        .lane_be    (lane_be),
        .rdata      (align_rdata)
    );

    // Word address wraps naturally at MEM_DEPTH through WW-bit truncation.
    assign o_mem_en    = mem_en;
    assign o_mem_we    = (mem_en & we_q) ? lane_be : '0;
    assign o_mem_addr  = mem_en ? (word_base + WW'(beat_q)) : '0;
    assign o_mem_wdata = mem_en ? lane_wdata : '0;
    assign o_err       = o_done & err_q;
    assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl (16-bit and 8-bit memories)
module tb_mem_access_ctrl;

    typedef struct {
        int          addr;
        logic [1:0]  we;
        logic [15:0] wd;
    } beat_t;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          lat;
    } resp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_init = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   acc_a = 0;
    int   acc_b = 0;

    beat_t bq_a[$];
    beat_t bq_b[$];
    resp_t rq_a[$];
    resp_t rq_b[$];

    // DUT A: 16-bit words, 16 words deep
    logic        req_a = 1'b0, we_a = 1'b0, sgn_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic [4:0]  addr_a = '0;
    logic [31:0] wdata_a = '0;
    logic        ready_a, done_a, err_a, en_a;
    logic [31:0] rdata_a;
    logic [1:0]  mwe_a;
    logic [3:0]  maddr_a;
    logic [15:0] mwd_a, mrd_a;
    logic [15:0] mem_a [16];

    // DUT B: 8-bit words, 16 words deep
    logic        req_b = 1'b0, we_b = 1'b0, sgn_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic [3:0]  addr_b = '0;
    logic [31:0] wdata_b = '0;
    logic        ready_b, done_b, err_b, en_b;
    logic [31:0] rdata_b;
    logic [0:0]  mwe_b;
    logic [3:0]  maddr_b;
    logic [7:0]  mwd_b, mrd_b;
    logic [7:0]  mem_b [16];

    mem_access_ctrl #(.MEM_WIDTH(16), .MEM_DEPTH(16)) dut_a (
        .clk(clk), .rst(rst), .i_req(req_a), .i_we(we_a), .i_mode(mode_a),
        .i_signed(sgn_a), .i_addr(addr_a), .i_wdata(wdata_a), .o_ready(ready_a),
        .o_done(done_a), .o_err(err_a), .o_rdata(rdata_a), .o_mem_en(en_a),
        .o_mem_we(mwe_a), .o_mem_addr(maddr_a), .o_mem_wdata(mwd_a), .i_mem_rdata(mrd_a)
    );

    mem_access_ctrl #(.MEM_WIDTH(8), .MEM_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .i_req(req_b), .i_we(we_b), .i_mode(mode_b),
        .i_signed(sgn_b), .i_addr(addr_b), .i_wdata(wdata_b), .o_ready(ready_b),
        .o_done(done_b), .o_err(err_b), .o_rdata(rdata_b), .o_mem_en(en_b),
        .o_mem_we(mwe_b), .o_mem_addr(maddr_b), .o_mem_wdata(mwd_b), .i_mem_rdata(mrd_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Memory models with one-cycle read latency; B is preloaded 11 22 33 44 at words 12..15.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= 16'h0000;
                mem_b[i] <= (i >= 12) ? 8'(17 * (i - 11)) : 8'h00;
            end
        end else begin
            if (en_a) begin
                mrd_a <= mem_a[maddr_a];
                for (int l = 0; l < 2; l++) begin
                    if (mwe_a[l]) mem_a[maddr_a][8*l +: 8] <= mwd_a[8*l +: 8];
                end
            end
            if (en_b) begin
                mrd_b <= mem_b[maddr_b];
                if (mwe_b[0]) mem_b[maddr_b] <= mwd_b;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic fail_event(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: actual event with empty expectation queue, required none", nm);
    endtask

    task automatic eb(input int d, input int addr, input logic [1:0] we, input logic [15:0] wd);
        beat_t b;
        b.addr = addr; b.we = we; b.wd = wd;
        if (d == 0) bq_a.push_back(b); else bq_b.push_back(b);
    endtask

    task automatic er(input int d, input logic err, input logic [31:0] rd, input int lat);
        resp_t r;
        r.err = err; r.rd = rd; r.lat = lat;
        if (d == 0) rq_a.push_back(r); else rq_b.push_back(r);
    endtask

    // Monitor A
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (!rst) begin
            if (req_a && ready_a) acc_a = cyc;
            if (en_a) begin
                if (bq_a.size() == 0) fail_event("a_beat");
                else begin
                    b = bq_a.pop_front();
                    check("a_beat_addr", 32'(maddr_a), 32'(b.addr));
                    check("a_beat_we", 32'(mwe_a), 32'(b.we));
                    if (b.we != 2'b00) check("a_beat_wdata", 32'(mwd_a), 32'(b.wd));
                end
            end
            if (done_a) begin
                if (rq_a.size() == 0) fail_event("a_done");
                else begin
                    r = rq_a.pop_front();
                    check("a_err", 32'(err_a), 32'(r.err));
                    check("a_rdata", rdata_a, r.rd);
                    check("a_latency", 32'(cyc - acc_a), 32'(r.lat));
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        beat_t b;
        resp_t r;
        if (!rst) begin
            if (req_b && ready_b) acc_b = cyc;
            if (en_b) begin
                if (bq_b.size() == 0) fail_event("b_beat");
                else begin
                    b = bq_b.pop_front();
                    check("b_beat_addr", 32'(maddr_b), 32'(b.addr));
                    check("b_beat_we", 32'(mwe_b), 32'(b.we));
                    if (b.we != 2'b00) check("b_beat_wdata", 32'(mwd_b), 32'(b.wd));
                end
            end
            if (done_b) begin
                if (rq_b.size() == 0) fail_event("b_done");
                else begin
                    r = rq_b.pop_front();
                    check("b_err", 32'(err_b), 32'(r.err));
                    check("b_rdata", rdata_b, r.rd);
                    check("b_latency", 32'(cyc - acc_b), 32'(r.lat));
                end
            end
        end
    end

    function automatic logic rdy(input int d);
        return (d == 0) ? ready_a : ready_b;
    endfunction

    task automatic drive(input int d, input logic r, input logic we, input logic [1:0] mode,
                         input logic sgn, input logic [7:0] addr, input logic [31:0] wd);
        if (d == 0) begin
            req_a = r; we_a = we; mode_a = mode; sgn_a = sgn; addr_a = addr[4:0]; wdata_a = wd;
        end else begin
            req_b = r; we_b = we; mode_b = mode; sgn_b = sgn; addr_b = addr[3:0]; wdata_b = wd;
        end
    endtask

    // One request; 'hold' keeps i_req high (with scrambled inputs) while busy.
    task automatic issue(input int d, input logic we, input logic [1:0] mode, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wd, input int hold);
        int t;
        t = 0;
        while (!rdy(d) && t < 30) begin @(posedge clk); #1; t++; end
        if (!rdy(d)) begin
            fail_event("ready_before_request_timeout");
            return;
        end
        drive(d, 1'b1, we, mode, sgn, addr, wd);
        @(posedge clk); #1;
        if (hold > 0) begin
            drive(d, 1'b1, we, mode, sgn, 8'h00, ~wd);
            repeat (hold) begin @(posedge clk); #1; end
        end
        drive(d, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
        t = 0;
        while (!rdy(d) && t < 30) begin @(posedge clk); #1; t++; end
        if (!rdy(d)) fail_event("completion_timeout");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_mem_en", 32'(en_a), 32'd0);
        check("rst_mem_we", 32'(mwe_a), 32'd0);
        check("rst_mem_addr", 32'(maddr_a), 32'd0);
        check("rst_mem_wdata", 32'(mwd_a), 32'd0);
        check("rst_rdata", rdata_a, 32'd0);
        check("rst_ready_b", 32'(ready_b), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready_a", 32'(ready_a), 32'd1);
        check("post_rst_ready_b", 32'(ready_b), 32'd1);
        @(posedge clk); #1;

        // 16-bit memory
        eb(0, 8, 2'b11, 16'hC3D4); eb(0, 9, 2'b11, 16'hA1B2); er(0, 0, 32'h0, 3);
        issue(0, 1, 2'd2, 0, 8'h10, 32'hA1B2C3D4, 0);
        eb(0, 8, 2'b00, 16'h0); eb(0, 9, 2'b00, 16'h0); er(0, 0, 32'hA1B2C3D4, 4);
        issue(0, 0, 2'd2, 0, 8'h10, 32'h0, 0);
        eb(0, 8, 2'b10, 16'h8080); er(0, 0, 32'hA1B2C3D4, 2);
        issue(0, 1, 2'd3, 0, 8'h11, 32'h5A5A5A80, 0);
        eb(0, 8, 2'b00, 16'h0); er(0, 0, 32'hFFFFFF80, 3);
        issue(0, 0, 2'd3, 1, 8'h11, 32'h0, 0);
        eb(0, 8, 2'b00, 16'h0); er(0, 0, 32'h00000080, 3);
        issue(0, 0, 2'd3, 0, 8'h11, 32'h0, 0);
        er(0, 1, 32'h00000080, 1);
        issue(0, 0, 2'd1, 0, 8'h03, 32'h0, 0);
        er(0, 1, 32'h00000080, 1);
        issue(0, 1, 2'd0, 0, 8'h00, 32'hFFFFFFFF, 0);
        er(0, 1, 32'h00000080, 1);
        issue(0, 1, 2'd2, 0, 8'h12, 32'h11111111, 0);
        eb(0, 9, 2'b11, 16'hBEEF); er(0, 0, 32'h00000080, 2);
        issue(0, 1, 2'd1, 0, 8'h12, 32'h1234BEEF, 0);
        eb(0, 9, 2'b00, 16'h0); er(0, 0, 32'hFFFFBEEF, 3);
        issue(0, 0, 2'd1, 1, 8'h12, 32'h0, 0);
        eb(0, 8, 2'b00, 16'h0); eb(0, 9, 2'b00, 16'h0); er(0, 0, 32'hBEEF80D4, 4);
        issue(0, 0, 2'd2, 1, 8'h10, 32'h0, 0);
        eb(0, 14, 2'b11, 16'h0304); eb(0, 15, 2'b11, 16'h0102); er(0, 0, 32'hBEEF80D4, 3);
        issue(0, 1, 2'd2, 0, 8'h1C, 32'h01020304, 0);
        eb(0, 14, 2'b00, 16'h0); eb(0, 15, 2'b00, 16'h0); er(0, 0, 32'h01020304, 4);
        issue(0, 0, 2'd2, 0, 8'h1C, 32'h0, 0);
        eb(0, 12, 2'b11, 16'hF00D); eb(0, 13, 2'b11, 16'h0BAD); er(0, 0, 32'h01020304, 3);
        issue(0, 1, 2'd2, 0, 8'h18, 32'h0BADF00D, 3);
        eb(0, 12, 2'b00, 16'h0); eb(0, 13, 2'b00, 16'h0); er(0, 0, 32'h0BADF00D, 4);
        issue(0, 0, 2'd2, 0, 8'h18, 32'h0, 0);

        // 8-bit memory
        eb(1, 12, 2'b00, 16'h0); eb(1, 13, 2'b00, 16'h0);
        eb(1, 14, 2'b00, 16'h0); eb(1, 15, 2'b00, 16'h0); er(1, 0, 32'h44332211, 6);
        issue(1, 0, 2'd2, 0, 8'h0C, 32'h0, 0);
        er(1, 1, 32'h44332211, 1);
        issue(1, 0, 2'd2, 0, 8'h0E, 32'h0, 0);
        eb(1, 14, 2'b01, 16'h00FE); eb(1, 15, 2'b01, 16'h00CA); er(1, 0, 32'h44332211, 3);
        issue(1, 1, 2'd1, 0, 8'h0E, 32'h0000CAFE, 0);
        eb(1, 14, 2'b00, 16'h0); eb(1, 15, 2'b00, 16'h0); er(1, 0, 32'h0000CAFE, 4);
        issue(1, 0, 2'd1, 0, 8'h0E, 32'h0, 0);
        eb(1, 15, 2'b00, 16'h0); er(1, 0, 32'hFFFFFFCA, 3);
        issue(1, 0, 2'd3, 1, 8'h0F, 32'h0, 0);

        // Reset in cycle 2 of a 32-bit store: only beat 0 reaches memory.
        eb(0, 10, 2'b11, 16'h7788);
        drive(0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h14, 32'h55667788);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_mem_en", 32'(en_a), 32'd0);
        check("rst_mid_ready", 32'(ready_a), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_release_ready", 32'(ready_a), 32'd1);
        check("rst_release_done", 32'(done_a), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_mid_word10", 32'(mem_a[10]), 32'h7788);
        check("rst_mid_word11", 32'(mem_a[11]), 32'h0000);

        check("a_beats_left", 32'(bq_a.size()), 32'd0);
        check("a_resps_left", 32'(rq_a.size()), 32'd0);
        check("b_beats_left", 32'(bq_b.size()), 32'd0);
        check("b_resps_left", 32'(rq_b.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
